uart_tx_fifo: RTL and testbench

Transmit-side buffer that sits directly upstream of the `uart` core. It accepts bytes from a host at full clock rate, stores up to `DEPTH` of them, and feeds them one at a time into the UART's `start`/`txin` inputs. It pops the next byte only after the UART reports `txdone`, so the host can burst-write a packet without tracking UART frame timing.

---
 rtl/uart_tx_fifo_if.sv | 26 ++
 rtl/uart_tx_fifo.sv | 81 ++++++++
 tb/tb_uart_tx_fifo.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - host write port and UART feed signals of uart_tx_fifo
interface uart_tx_fifo_if #(
   parameter int DW = 8,
   parameter int AW = 4
);
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          busy;
   logic          uart_start;
   logic [DW-1:0] uart_txin;
   logic          uart_txdone;

   modport master (
      output wr_en, wr_data, uart_txdone,
      input  full, empty, count, overflow, busy, uart_start, uart_txin
   );

   modport slave (
      input  wr_en, wr_data, uart_txdone,
      output full, empty, count, overflow, busy, uart_start, uart_txin
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that feeds a UART one frame at a time, popping only after txdone
module uart_tx_fifo #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input logic            clk,
   input logic            rst,
   uart_tx_fifo_if.slave  bus
);
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t        state, state_nxt;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count_q;
   logic [DW-1:0] txin_q;
   logic          ovf_q;
   logic          wr_ok, pop, start_c;

   assign bus.count     = count_q;
   assign bus.full      = (count_q == (AW+1)'(DEPTH));
   assign bus.empty     = (count_q == '0);
   assign bus.overflow  = ovf_q;
   assign bus.busy      = (state != IDLE);
   assign bus.uart_txin = txin_q;
   assign bus.uart_start = start_c;

   // full blocks a write even when a pop frees a slot on the same edge
   assign wr_ok = bus.wr_en && !bus.full;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      start_c   = 1'b0;
      case (state)
         IDLE: begin
            if (!bus.empty) begin
               pop       = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            start_c = 1'b1;
            if (bus.uart_txdone) state_nxt = GAP;
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         txin_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (bus.wr_en && bus.full) ovf_q <= 1'b1;
         if (pop) begin
            txin_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // storage is deliberately not reset; only entries between the pointers are ever read
   always_ff @(posedge clk) begin
      if (wr_ok && !rst) mem[wr_ptr] <= bus.wr_data;
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DW(8), .AW(4)) bus ();
   uart_tx_fifo #(.DW(8), .AW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   // reference: bytes accepted but not yet seen at uart_txin, plus frame phase
   logic [7:0] sb_q[$];
   int  m_cnt = 0, m_phase = 0, m_age = 0, m_acc = 0;
   bit  m_ovf = 1'b0;
   int  lat = 20;
   bit  hold_done = 1'b0, stray_en = 1'b0, saw_full = 1'b0;

   int  rises = 0, gap = 0;
   bit  prev_start = 1'b0, gap_valid = 1'b0, gap_exact = 1'b0;
   logic [7:0] held = '0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(bit r, bit we, logic [7:0] d);
      bit td, pp, wok;
      td = (m_phase == 1 && !hold_done && m_age >= lat) ||
           (m_phase != 1 && stray_en && $urandom_range(0, 3) == 0);
      rst = r;
      bus.wr_en = we;
      bus.wr_data = d;
      bus.uart_txdone = td;
      @(posedge clk);
      if (r) begin
         m_cnt = 0; m_phase = 0; m_age = 0; m_ovf = 1'b0;
         sb_q.delete();
      end else begin
         pp  = (m_phase == 0 && m_cnt > 0);
         wok = we && m_cnt < 16;
         if (we && !wok) m_ovf = 1'b1;
         if (wok) begin
            sb_q.push_back(d);
            m_acc++;
         end
         m_cnt = m_cnt + int'(wok) - int'(pp);
         case (m_phase)
            0: if (pp) begin m_phase = 1; m_age = 0; end
            1: if (td) m_phase = 2; else m_age++;
            default: m_phase = 0;
         endcase
      end
      #1;
      check("count", 32'(bus.count), 32'(m_cnt));
      check("full", 32'(bus.full), 32'(m_cnt == 16));
      check("empty", 32'(bus.empty), 32'(m_cnt == 0));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("busy", 32'(bus.busy), 32'(m_phase != 0));
      check("uart_start", 32'(bus.uart_start), 32'(m_phase == 1));
      if (bus.full === 1'b1) saw_full = 1'b1;
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 3000 && !(m_phase == 0 && m_cnt == 0); i++) step(1'b0, 1'b0, 8'h00);
      check("drain_done", 32'(m_phase == 0 && m_cnt == 0), 32'd1);
      step(1'b0, 1'b0, 8'h00);
   endtask

   // monitor: each new frame must carry the oldest accepted byte
   always @(negedge clk) begin
      if (bus.uart_start === 1'b1) begin
         if (!prev_start) begin
            rises++;
            check("frame_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) check("txin", 32'(bus.uart_txin), 32'(sb_q.pop_front()));
            if (gap_valid) begin
               if (gap_exact) check("gap_len", 32'(gap), 32'd2);
               else check("gap_min", 32'(gap >= 2), 32'd1);
            end
            gap_valid = 1'b0;
            held = bus.uart_txin;
         end else begin
            check("txin_stable", 32'(bus.uart_txin), 32'(held));
         end
      end else begin
         if (prev_start) begin
            gap = 0;
            gap_valid = 1'b1;
            gap_exact = (m_cnt != 0);
         end
         gap++;
      end
      prev_start = (bus.uart_start === 1'b1);
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, a0, n, blen;
      rst = 1'b1;
      bus.wr_en = 1'b0;
      bus.wr_data = '0;
      bus.uart_txdone = 1'b0;

      step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'h00);
      check("reset_txin", 32'(bus.uart_txin), 32'h0);
      check("reset_start", 32'(bus.uart_start), 32'd0);

      // single byte with a slow UART
      lat = 20;
      step(1'b0, 1'b1, 8'h5A);
      check("single_start_k", 32'(bus.uart_start), 32'd0);
      step(1'b0, 1'b0, 8'h00);
      check("single_start_k1", 32'(bus.uart_start), 32'd1);
      check("single_txin", 32'(bus.uart_txin), 32'h5A);
      drain();
      check("single_rises", 32'(rises), 32'd1);

      // 16-byte burst into an idle UART
      lat = 3;
      saw_full = 1'b0;
      r0 = rises;
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
      drain();
      check("burst_no_full", 32'(saw_full), 32'd0);
      check("burst_frames", 32'(rises - r0), 32'd16);

      // write on the same edge as an IDLE pop with three bytes stored
      hold_done = 1'b1;
      lat = 2;
      step(1'b0, 1'b1, 8'hA0);
      step(1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 8'(8'hA0 + i));
      check("simul_pre_count", 32'(bus.count), 32'd3);
      hold_done = 1'b0;
      for (int i = 0; i < 100 && m_phase != 0; i++) step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'hA4);
      check("simul_count", 32'(bus.count), 32'd3);
      check("simul_start", 32'(bus.uart_start), 32'd1);
      drain();

      // mixed random bursts, wraps the pointers several times
      stray_en = 1'b1;
      r0 = rises;
      a0 = m_acc;
      n = 0;
      while (n < 40) begin
         blen = $urandom_range(1, 8);
         lat = $urandom_range(0, 3);
         for (int i = 0; i < blen && n < 40; i++) begin
            step(1'b0, 1'b1, 8'($urandom));
            n++;
         end
         for (int i = $urandom_range(0, 10); i > 0; i--) step(1'b0, 1'b0, 8'h00);
      end
      drain();
      check("wrap_frames", 32'(rises - r0), 32'(m_acc - a0));

      // overflow with the UART stalled on the first byte
      stray_en = 1'b0;
      hold_done = 1'b1;
      lat = 1;
      step(1'b0, 1'b1, 8'hC0);
      step(1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 18; i++) step(1'b0, 1'b1, 8'(8'hC0 + i));
      check("ovf_count", 32'(bus.count), 32'd16);
      check("ovf_full", 32'(bus.full), 32'd1);
      check("ovf_flag", 32'(bus.overflow), 32'd1);
      r0 = rises;
      hold_done = 1'b0;
      drain();
      check("ovf_frames", 32'(rises - r0), 32'd16);
      check("ovf_sticky", 32'(bus.overflow), 32'd1);

      // reset in the middle of a frame with five bytes waiting
      hold_done = 1'b1;
      step(1'b0, 1'b1, 8'hD0);
      step(1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'(8'hD0 + i));
      check("mid_count", 32'(bus.count), 32'd5);
      step(1'b1, 1'b0, 8'h00);
      check("mid_start", 32'(bus.uart_start), 32'd0);
      check("mid_count_rst", 32'(bus.count), 32'd0);
      check("mid_ovf_rst", 32'(bus.overflow), 32'd0);
      hold_done = 1'b0;
      stray_en = 1'b1;
      r0 = rises;
      for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 8'h00);
      check("mid_no_start", 32'(rises - r0), 32'd0);
      check("mid_busy", 32'(bus.busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
